lsu_mem_ctrl: RTL
=================

LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 10: byte-address width of the attached 8-bit synchronous RAM.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  in  1  request present.
REQ-005 SHALL have port req_ready  out  1  request accepted when high with req_valid on a clk edge.
REQ-006 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-009 SHALL have port req_addr  in  ADDR_W  byte address.
REQ-010 SHALL have port req_wdata  in  32  store data; bits [8i+7:8i] form byte i.
REQ-011 SHALL have port resp_valid  out  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  out  32  load result.
REQ-013 SHALL have port resp_err  out  1  request rejected; qualified by resp_valid.
REQ-014 SHALL have port mem_we  out  1  RAM write enable.
REQ-015 SHALL have port mem_addr  out  ADDR_W  RAM address.
REQ-016 SHALL have port mem_wdata  out  8  RAM write data.
REQ-017 SHALL have port mem_rdata  in  8  RAM read data, registered inside the RAM: the byte addressed in cycle k, with mem_we=0, is valid in cycle k+1.

Function
REQ-018 SHALL implement states IDLE, WR, RD, RD_TAIL and RESP; req_ready=1 only in IDLE.
REQ-019 SHALL latch we, size, unsigned, addr and wdata on acceptance; inputs are ignored while not in IDLE.
REQ-020 SHALL set byte count N to 1/2/4 for size 00/01/10.
REQ-021 SHALL treat size 11, half with addr[0]=1, or word with addr[1:0]!=0 as an error: no RAM access, IDLE->RESP with resp_err=1 and resp_rdata=0.
REQ-022 SHALL, for a legal store, enter WR for N cycles; in cycle i: mem_we=1, mem_addr=base+i, mem_wdata=byte i (little-endian); then RESP.
REQ-023 SHALL, for a legal load, enter RD for N cycles driving mem_we=0 and mem_addr=base+i in cycle i, capturing mem_rdata as byte i-1 in cycles 1..N-1.
REQ-024 SHALL capture the last byte in RD_TAIL, then enter RESP.
REQ-025 SHALL compute base+i modulo 2^ADDR_W; aligned legal accesses never wrap.
REQ-026 SHALL assert resp_valid for exactly one cycle, in RESP, with no backpressure; RESP->IDLE unconditionally.
REQ-027 SHALL produce load results as follows: byte sign- or zero-extends bit 7; half extends bit 15; word passes through; stores and errors return resp_rdata=0.
REQ-028 SHALL hold resp_rdata and resp_err between responses.
REQ-029 SHALL have latency from accepting edge to resp_valid of: error 1 cycle, store N+1 cycles, load N+2 cycles.
REQ-030 SHALL drive mem_we=0, mem_addr=0 and mem_wdata=0 in IDLE, RD_TAIL and RESP; mem_wdata=0 in RD.
REQ-031 SHALL accept a request held valid through RESP on the first IDLE cycle after RESP.

Reset
REQ-032 SHALL, while rst_n=0, force state IDLE, mem_we=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_err=0 and resp_rdata=0 immediately, without waiting for clk.
REQ-033 SHALL abort any in-progress access on reset without generating a response; bytes already written remain in the RAM.

Verification
REQ-034 SHALL pass: SW addr 0x010, wdata 0xDEADBEEF -> mem_we high 4 cycles, addr 0x010..0x013, data EF,BE,AD,DE; resp_valid 5 cycles after accept, resp_err=0.
REQ-035 SHALL pass: LW 0x010 after REQ-034 -> resp_rdata=0xDEADBEEF 6 cycles after accept; mem_we stays 0.
REQ-036 SHALL pass: LB 0x012 signed -> 0xFFFFFFAD; LBU 0x012 -> 0x000000AD; LH 0x012 signed -> 0xFFFFDEAD; LHU 0x012 -> 0x0000DEAD.
REQ-037 SHALL pass: LW 0x011, SH 0x013 and size 11 -> resp_err=1 and resp_rdata=0 one cycle after accept, with no mem_we pulse.
REQ-038 SHALL pass: rst_n low after 2 WR cycles of SW 0x020 with 0x11223344 -> mem_we drops immediately, RAM[0x020]=0x44 and RAM[0x021]=0x33, no resp_valid, req_ready=1 after release.
REQ-039 SHALL pass: req_valid held high across back-to-back LB requests -> req_ready=0 while busy, second request accepted the cycle after RESP.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: byte-serial load/store unit for an 8-bit synchronous RAM
module lsu_mem_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);
  typedef enum logic [2:0] {IDLE, WR, RD, RD_TAIL, RESP} state_t;
  state_t state, state_nx;
  logic uns_q, err, last;
  logic [1:0] size_q, cnt, idx;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0] wdata_q, rbuf, merged, ld;
  assign err = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0]) ||
               (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  // cnt reaches N-1 on the final byte: 0, 1 or 3
  assign last = cnt == {size_q[1], |size_q};
  // RAM data lags the address by one cycle, so it belongs to byte cnt-1
  assign idx = cnt - 2'd1;
  assign resp_valid = state == RESP;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    req_ready = 1'b0;
    mem_we = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = err ? RESP : req_we ? WR : RD;
      end
      WR: begin
        mem_we = 1'b1;
        mem_addr = addr_q + ADDR_W'(cnt);
        mem_wdata = wdata_q[{cnt, 3'b000} +: 8];
        if (last) state_nx = RESP;
      end
      RD: begin
        mem_addr = addr_q + ADDR_W'(cnt);
        if (last) state_nx = RD_TAIL;
      end
      RD_TAIL: state_nx = RESP;
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    merged = rbuf;
    merged[{idx, 3'b000} +: 8] = mem_rdata;
  end
  assign ld = size_q == 2'b00 ? {{24{~uns_q & merged[7]}}, merged[7:0]} :
              size_q == 2'b01 ? {{16{~uns_q & merged[15]}}, merged[15:0]} : merged;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uns_q <= 1'b0;
      size_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      cnt <= '0;
      rbuf <= '0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          uns_q <= req_unsigned;
          size_q <= req_size;
          addr_q <= req_addr;
          wdata_q <= req_wdata;
          cnt <= '0;
          if (err) begin
            resp_err <= 1'b1;
            resp_rdata <= '0;
          end
        end
        WR: begin
          cnt <= cnt + 2'd1;
          if (last) begin
            resp_err <= 1'b0;
            resp_rdata <= '0;
          end
        end
        RD: begin
          cnt <= cnt + 2'd1;
          if (cnt != 2'd0) rbuf[{idx, 3'b000} +: 8] <= mem_rdata;
        end
        RD_TAIL: begin
          resp_err <= 1'b0;
          resp_rdata <= ld;
        end
        default: ;
      endcase
    end
  end
endmodule
